// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers VGA line/frame timing from the bus, locks to the expected geometry, reports pixels and a per-frame RGB checksum.
// Bus layout: [13] hsync, [12] vsync, [11:0] {r[3:0], g[3:0], b[3:0]}.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 1056,
  parameter int V_TOTAL     = 628,
  parameter int H_START     = 216,
  parameter int V_START     = 27,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int SYNC_ACTIVE = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] vga_bus_in,
  output logic        locked,
  output logic        pixel_valid,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        frame_done,
  output logic [23:0] frame_sum,
  output logic [7:0]  err_cnt
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  localparam logic SA = 1'(SYNC_ACTIVE);
  state_t      state, state_n;
  logic [1:0]  rs;
  logic        rst_s;
  logic [13:0] s1;
  logic        hs_d, vs_d, hs_edge, vs_edge;
  logic [11:0] t_cnt, t_pos;
  logic [10:0] h_pos, v_cnt, v_pos;
  logic        line_err, timeout, good, started, lerr_seen, pv_n, err_inc, sum_load;
  logic [7:0]  gc, gc_n;
  logic [23:0] acc;
  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rs <= 2'b00;
    else rs <= {rs[0], 1'b1};
  assign rst_s = rs[1];
  // t_cnt counts clocks since the last hsync edge past h_cnt's 2047 ceiling, so the no-hsync timeout can be seen.
  assign hs_edge  = (s1[13] == SA) && !hs_d;
  assign vs_edge  = (s1[12] == SA) && !vs_d;
  assign t_pos    = hs_edge ? '0 : (&t_cnt ? t_cnt : t_cnt + 12'd1);
  assign h_pos    = t_pos[11] ? 11'h7FF : t_pos[10:0];
  assign v_pos    = vs_edge ? '0 : (hs_edge && !(&v_cnt)) ? v_cnt + 11'd1 : v_cnt;
  assign timeout  = int'(t_pos) == 2 * H_TOTAL;
  assign line_err = hs_edge && (int'(t_cnt) + 1 != H_TOTAL);
  assign good     = vs_edge && hs_edge && started && !lerr_seen && !line_err && (int'(v_cnt) + 1 == V_TOTAL);
  assign pv_n     = (state == LOCKED) && int'(h_pos) >= H_START && int'(h_pos) < H_START + H_ACTIVE &&
                    int'(v_pos) >= V_START && int'(v_pos) < V_START + V_ACTIVE;
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      state <= SEARCH;
      gc    <= '0;
    end else begin
      state <= state_n;
      gc    <= gc_n;
    end
  always_comb begin
    state_n = state;
    gc_n    = gc;
    if (timeout) state_n = SEARCH;
    else if (state == SEARCH) begin
      if (vs_edge) begin
        state_n = TRACK;
        gc_n    = '0;
      end
    end else if (state == TRACK) begin
      if (vs_edge) begin
        gc_n = good ? gc + 8'd1 : '0;
        if (good && int'(gc) + 1 >= LOCK_FRAMES) state_n = LOCKED;
      end
    end else if (line_err || (vs_edge && !good)) begin
      state_n = TRACK;
      gc_n    = '0;
    end
  end
  always_comb begin
    locked   = state == LOCKED;
    err_inc  = (state == LOCKED) && (timeout || line_err || (vs_edge && !good));
    sum_load = (state == LOCKED) && (state_n == LOCKED) && good;
  end
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      s1          <= '0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      t_cnt       <= '0;
      v_cnt       <= '0;
      started     <= 1'b0;
      lerr_seen   <= 1'b0;
      acc         <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      err_cnt     <= '0;
    end else begin
      s1          <= vga_bus_in;
      hs_d        <= s1[13] == SA;
      vs_d        <= s1[12] == SA;
      t_cnt       <= t_pos;
      v_cnt       <= v_pos;
      started     <= timeout ? 1'b0 : (vs_edge || started);
      lerr_seen   <= !vs_edge && (lerr_seen || line_err);
      acc         <= vs_edge ? '0 : pv_n ? acc + {12'd0, s1[11:0]} : acc;
      pixel_valid <= pv_n;
      pixel_x     <= pv_n ? h_pos - 11'(H_START) : '0;
      pixel_y     <= pv_n ? v_pos - 11'(V_START) : '0;
      pixel_rgb   <= pv_n ? s1[11:0] : '0;
      frame_done  <= sum_load;
      frame_sum   <= sum_load ? acc : frame_sum;
      err_cnt     <= (err_inc && !(&err_cnt)) ? err_cnt + 8'd1 : err_cnt;
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of lock, pixel reporting, checksum and error recovery on a reduced 48x16 geometry.
// Active area is 32x10 = 320 pixels per frame; bus hsync = h<4, vsync = v<2.
module tb_vga_sync_decoder;
  localparam int H = 48, V = 16, HST = 10, VST = 3, HA = 32, VA = 10;
  logic        clk = 1'b0, rst = 1'b0;
  logic [13:0] bus = '0;
  logic        locked, pixel_valid, frame_done;
  logic [10:0] pixel_x, pixel_y;
  logic [11:0] pixel_rgb;
  logic [23:0] frame_sum;
  logic [7:0]  err_cnt;
  int total = 0, bad = 0, done_cnt = 0, d = 0;
  int gh = 0, gv = 0, short_v = -1;
  logic hs_kill = 1'b0, vs_off = 1'b0;
  logic [11:0] rgb = 12'h5A3;
  vga_sync_decoder #(.H_TOTAL(H), .V_TOTAL(V), .H_START(HST), .V_START(VST), .H_ACTIVE(HA),
                     .V_ACTIVE(VA), .SYNC_ACTIVE(1), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .vga_bus_in(bus), .locked(locked), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb), .frame_done(frame_done),
    .frame_sum(frame_sum), .err_cnt(err_cnt));
  always #5 clk = ~clk;
  // Bus source advances on the falling edge; gh/gv name the sample the next rising edge takes.
  always @(negedge clk) begin
    if (gh == ((gv == short_v) ? H - 2 : H - 1)) begin
      gh = 0;
      gv = (gv == V - 1) ? 0 : gv + 1;
    end else gh = gh + 1;
    bus = {!hs_kill && gh < 4, gv < 2 && !(vs_off && gv == 0 && gh == 0), rgb};
  end
  always @(posedge clk) if (frame_done) done_cnt++;
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task step();
    @(posedge clk);
    #1;
  endtask
  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task wait_at(input int v, input int h);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(gv == v && gh == h) && n < 3000);
    chk("wait_pos", 32'(gv == v && gh == h), 1);
  endtask
  task wait_done();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 3000);
    chk("done_seen", 32'(frame_done), 1);
  endtask
  task zeros(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_x"}, 32'(pixel_x), 0);
    chk({tag, "_y"}, 32'(pixel_y), 0);
    chk({tag, "_rgb"}, 32'(pixel_rgb), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_sum"}, 32'(frame_sum), 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
  endtask
  task lock_seq(input string tag, input int pre);
    repeat (pre) begin
      wait_at(0, 0);
      step();
      chk({tag, "_early"}, 32'(locked), 0);
    end
    wait_at(0, 0);
    chk({tag, "_pre"}, 32'(locked), 0);
    step();
    chk({tag, "_rise"}, 32'(locked), 1);
  endtask
  initial begin
    repeat (5) step();
    zeros("por");
    wait_at(8, 0);
    rst = 1'b1;
    lock_seq("lock", 2);
    wait_at(3, 10);
    chk("px_first_pre", 32'(pixel_valid), 0);
    step();
    chk("px_first_valid", 32'(pixel_valid), 1);
    chk("px_first_x", 32'(pixel_x), 0);
    chk("px_first_y", 32'(pixel_y), 0);
    chk("px_first_rgb", 32'(pixel_rgb), 32'h5A3);
    wait_at(12, 41);
    step();
    chk("px_last_valid", 32'(pixel_valid), 1);
    chk("px_last_x", 32'(pixel_x), 31);
    chk("px_last_y", 32'(pixel_y), 9);
    step();
    chk("px_after_valid", 32'(pixel_valid), 0);
    chk("px_after_x", 32'(pixel_x), 0);
    chk("px_after_rgb", 32'(pixel_rgb), 0);
    wait_done();
    chk("sum_5a3", 32'(frame_sum), 32'h070BC0);
    step();
    chk("done_pulse", 32'(frame_done), 0);
    wait_at(1, 0);
    rgb = 12'h001;
    wait_done();
    chk("sum_001", 32'(frame_sum), 32'h000140);
    wait_at(1, 0);
    rgb = 12'hFFF;
    wait_done();
    chk("sum_fff", 32'(frame_sum), 32'h13FEC0);
    chk("err_clean", 32'(err_cnt), 0);
    wait_at(5, 0);
    short_v = 5;
    wait_at(6, 0);
    short_v = -1;
    chk("short_pre", 32'(locked), 1);
    step();
    chk("short_drop", 32'(locked), 0);
    chk("short_err", 32'(err_cnt), 1);
    d = done_cnt;
    lock_seq("relock_short", 2);
    chk("short_no_done", 32'(done_cnt - d), 0);
    wait_at(5, 10);
    hs_kill = 1'b1;
    wait_at(7, 0);
    chk("kill_pre", 32'(locked), 1);
    step();
    chk("kill_drop", 32'(locked), 0);
    chk("kill_err", 32'(err_cnt), 2);
    wait_at(7, 10);
    hs_kill = 1'b0;
    lock_seq("relock_kill", 2);
    wait_at(5, 20);
    chk("rst_pre_valid", 32'(pixel_valid), 1);
    chk("rst_pre_sum", 32'(frame_sum), 32'h13FEC0);
    rst = 1'b0;
    #1;
    zeros("rst_async");
    step();
    zeros("rst_next");
    repeat (3) step();
    wait_at(8, 0);
    rst = 1'b1;
    d = done_cnt;
    wait_at(0, 0);
    step();
    chk("off_a", 32'(locked), 0);
    wait_at(0, 0);
    step();
    chk("off_b", 32'(locked), 0);
    wait_at(8, 0);
    vs_off = 1'b1;
    wait_at(0, 1);
    vs_off = 1'b0;
    step();
    chk("off_c", 32'(locked), 0);
    wait_at(0, 0);
    step();
    chk("off_gc_cleared", 32'(locked), 0);
    lock_seq("off_relock", 0);
    chk("off_no_done", 32'(done_cnt - d), 0);
    chk("off_err", 32'(err_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
